// File: rtl/stepper_pkg.sv
// ============================================================================
// Module      : stepper_pkg
// Description : Shared constants and helpers for the stepper pin monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package stepper_pkg;

    typedef logic [1:0] phase_idx_t;

    localparam phase_idx_t IDX_00 = 2'd0;
    localparam phase_idx_t IDX_10 = 2'd1;
    localparam phase_idx_t IDX_11 = 2'd2;
    localparam phase_idx_t IDX_01 = 2'd3;

    // JA bit positions, identical to the driver's pin map
    localparam int JA_W    = 6;
    localparam int JA_EN_A = 5;
    localparam int JA_EN_B = 4;
    localparam int JA_IN1  = 3;
    localparam int JA_IN2  = 2;
    localparam int JA_IN3  = 1;
    localparam int JA_IN4  = 0;

    localparam int ST_ERR_CMP = 31;
    localparam int ST_ERR_SEQ = 30;
    localparam int ST_DIR     = 29;
    localparam int ST_MOVING  = 28;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_BWD  = 2'd2,
        STEP_JUMP = 2'd3
    } step_kind_t;

    function automatic phase_idx_t phase_idx(input logic a, input logic b);
        phase_idx_t idx;
        case ({a, b})
            2'b00:   idx = IDX_00;
            2'b10:   idx = IDX_10;
            2'b11:   idx = IDX_11;
            default: idx = IDX_01;
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pin_filter.sv
// ============================================================================
// Module      : pin_filter
// Description : Two-flop synchronizer plus stability filter; pulses accept_o
//               once each time a new pattern has held FILTER_CYCLES samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pin_filter #(
    parameter int WIDTH         = 6,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] pins_o,
    output logic             accept_o
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             acc_q, acc_d;

    // The counter parks at FILTER_CYCLES so a held pattern is accepted once.
    always_comb begin
        cand_d = sync2_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q < 8'(FILTER_CYCLES)) begin
            cnt_d = cnt_q + 8'd1;
        end
        acc_d = (cnt_d == 8'(FILTER_CYCLES - 1));
        f_d   = acc_d ? sync2_q : f_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= 8'd0;
            f_q     <= '0;
            acc_q   <= 1'b0;
        end else begin
            sync1_q <= pins_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            acc_q   <= acc_d;
        end
    end

    assign pins_o   = f_q;
    assign accept_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/stepper_monitor.sv
// ============================================================================
// Module      : stepper_monitor
// Description : Decodes filtered stepper pins into position, direction,
//               step period and sticky protocol error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module stepper_monitor
    import stepper_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int POS_W         = 21,
    parameter int PER_W         = 22
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [5:0]       JA_in,
    input  logic             pos_load,
    input  logic [POS_W-1:0] pos_load_val,
    input  logic             err_clr,
    output logic [POS_W-1:0] position,
    output logic             step_pulse,
    output logic             dir,
    output logic             moving,
    output logic [PER_W-1:0] period,
    output logic             err_seq,
    output logic             err_cmp,
    output logic [31:0]      status
);

    logic [JA_W-1:0] f_w;
    logic            acc_w;

    pin_filter #(
        .WIDTH         (JA_W),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_pin_filter (
        .clk_i    (CLK100MHZ),
        .rst_ni   (CPU_RESETN),
        .pins_i   (JA_in),
        .pins_o   (f_w),
        .accept_o (acc_w)
    );

    logic             en_w, rise_w, cmp_w;
    phase_idx_t       idx_w, delta_w;
    step_kind_t       kind_w;

    logic [POS_W-1:0] pos_q, pos_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    phase_idx_t       ref_q, ref_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             moving_q, moving_d;
    logic             eseq_q, eseq_d;
    logic             ecmp_q, ecmp_d;

    always_comb begin
        en_w    = f_w[JA_EN_A] & f_w[JA_EN_B];
        idx_w   = phase_idx(f_w[JA_IN1], f_w[JA_IN3]);
        delta_w = idx_w - ref_q;
        rise_w  = acc_w & en_w & ~moving_q;
        kind_w  = STEP_NONE;
        if (acc_w && en_w && moving_q) begin
            case (delta_w)
                2'd1:    kind_w = STEP_FWD;
                2'd3:    kind_w = STEP_BWD;
                2'd2:    kind_w = STEP_JUMP;
                default: kind_w = STEP_NONE;
            endcase
        end
        cmp_w = acc_w & ((f_w[JA_EN_A] ^ f_w[JA_EN_B]) |
                         (en_w & ((f_w[JA_IN1] ~^ f_w[JA_IN2]) |
                                  (f_w[JA_IN3] ~^ f_w[JA_IN4]))));
    end

    // ref_idx tracks every accepted index: a step, a jump, an enable edge and
    // a disabled pin change all leave it equal to the new index.
    always_comb begin
        ref_d     = acc_w ? idx_w : ref_q;
        moving_d  = acc_w ? en_w : moving_q;
        step_d    = (kind_w == STEP_FWD) || (kind_w == STEP_BWD);
        dir_d     = dir_q;
        pos_d     = pos_q;
        period_d  = period_q;
        per_cnt_d = per_cnt_q;

        if (kind_w == STEP_FWD) begin
            dir_d = 1'b1;
            pos_d = pos_q + POS_W'(1);
        end else if (kind_w == STEP_BWD) begin
            dir_d = 1'b0;
            pos_d = pos_q - POS_W'(1);
        end
        if (pos_load) begin
            pos_d = pos_load_val;
        end

        if (rise_w || step_d) begin
            per_cnt_d = '0;
        end else if (moving_q && (per_cnt_q != '1)) begin
            per_cnt_d = per_cnt_q + PER_W'(1);
        end
        if (step_d) begin
            period_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_W'(1);
        end

        eseq_d = (kind_w == STEP_JUMP) | (eseq_q & ~err_clr);
        ecmp_d = cmp_w | (ecmp_q & ~err_clr);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pos_q     <= '0;
            period_q  <= '0;
            per_cnt_q <= '0;
            ref_q     <= IDX_00;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            moving_q  <= 1'b0;
            eseq_q    <= 1'b0;
            ecmp_q    <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            period_q  <= period_d;
            per_cnt_q <= per_cnt_d;
            ref_q     <= ref_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            moving_q  <= moving_d;
            eseq_q    <= eseq_d;
            ecmp_q    <= ecmp_d;
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_ERR_CMP]     = ecmp_q;
        status[ST_ERR_SEQ]     = eseq_q;
        status[ST_DIR]         = dir_q;
        status[ST_MOVING]      = moving_q;
        status[POS_W-1:0]      = pos_q;
    end

    assign position   = pos_q;
    assign step_pulse = step_q;
    assign dir        = dir_q;
    assign moving     = moving_q;
    assign period     = period_q;
    assign err_seq    = eseq_q;
    assign err_cmp    = ecmp_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_monitor.sv
// ============================================================================
// Module      : tb_stepper_monitor
// Description : Self-checking bench for stepper_monitor with a pin-level
//               behavioural model, directed scenarios and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stepper_monitor;

    localparam int F     = 4;
    localparam int POS_W = 21;
    localparam int PER_W = 22;
    localparam int PER_MAX = (1 << PER_W) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [5:0]       ja = 6'd0;
    logic             pos_load = 1'b0;
    logic [POS_W-1:0] pos_load_val = '0;
    logic             err_clr = 1'b0;

    logic [POS_W-1:0] position;
    logic             step_pulse, dir, moving, err_seq, err_cmp;
    logic [PER_W-1:0] period;
    logic [31:0]      status;

    always #5 clk = ~clk;

    stepper_monitor #(
        .FILTER_CYCLES (F),
        .POS_W         (POS_W),
        .PER_W         (PER_W)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rstn),
        .JA_in        (ja),
        .pos_load     (pos_load),
        .pos_load_val (pos_load_val),
        .err_clr      (err_clr),
        .position     (position),
        .step_pulse   (step_pulse),
        .dir          (dir),
        .moving       (moving),
        .period       (period),
        .err_seq      (err_seq),
        .err_cmp      (err_cmp),
        .status       (status)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_steps  = 0;
    bit  chk_on   = 1'b0;
    bit  rnd_ctl  = 1'b0;

    // Model state: pin-domain run lengths feed a queue of accepted vectors,
    // each applied three edges after its run reaches F samples.
    typedef struct {
        int         due;
        logic [5:0] v;
    } ev_t;
    ev_t              evq[$];
    int               n_edge = 0;
    logic [5:0]       last_s;
    int               run;
    logic [POS_W-1:0] m_pos;
    logic [PER_W-1:0] m_period;
    int               m_mark, m_ref;
    logic             m_dir, m_mov, m_eseq, m_ecmp, m_step;
    int               idx_of[4] = '{0, 3, 1, 2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] vec(input logic en, input int p);
        logic a, b;
        a = (p == 1) || (p == 2);
        b = (p == 2) || (p == 3);
        return {en, en, a, ~a, b, ~b};
    endfunction

    task automatic model_reset();
        evq.delete();
        last_s = 6'd0;  run = F + 1;
        m_pos = '0;     m_period = '0;  m_mark = 0;  m_ref = 0;
        m_dir = 1'b1;   m_mov = 1'b0;   m_eseq = 1'b0;  m_ecmp = 1'b0;  m_step = 1'b0;
    endtask

    task automatic model_edge();
        ev_t        e;
        logic [5:0] v;
        logic       en, new_seq, new_cmp;
        int         idx, d;
        n_edge++;
        m_step  = 1'b0;
        new_seq = 1'b0;
        new_cmp = 1'b0;
        if (ja == last_s) begin
            if (run <= F) run++;
        end else begin
            run = 1;
            last_s = ja;
        end
        if (run == F) evq.push_back('{n_edge + 3, ja});
        if (evq.size() > 0 && evq[0].due == n_edge) begin
            e   = evq.pop_front();
            v   = e.v;
            en  = v[5] & v[4];
            idx = idx_of[{v[3], v[1]}];
            new_cmp = (v[5] != v[4]) || (en && (v[3] == v[2] || v[1] == v[0]));
            if (en && !m_mov) begin
                m_mark = n_edge;
            end else if (en) begin
                d = (idx - m_ref + 4) % 4;
                if (d == 1 || d == 3) begin
                    m_step = 1'b1;
                    m_dir  = (d == 1);
                    m_pos  = (d == 1) ? m_pos + 1'b1 : m_pos - 1'b1;
                    m_period = PER_W'(((n_edge - m_mark) > PER_MAX) ? PER_MAX : (n_edge - m_mark));
                    m_mark = n_edge;
                end else if (d == 2) begin
                    new_seq = 1'b1;
                end
            end
            m_ref = idx;
            m_mov = en;
        end
        if (pos_load) m_pos = pos_load_val;
        m_eseq = new_seq | (m_eseq & ~err_clr);
        m_ecmp = new_cmp | (m_ecmp & ~err_clr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_edge();
        @(negedge clk);
    endtask

    task automatic hold(input logic [5:0] v, input int cyc);
        ja = v;
        repeat (cyc) begin
            if (rnd_ctl) begin
                pos_load     = ($urandom_range(0, 63) == 0);
                pos_load_val = POS_W'($urandom);
                err_clr      = ($urandom_range(0, 39) == 0);
            end
            tick();
        end
        pos_load = 1'b0;
        err_clr  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("position",   32'(position),   32'(m_pos));
            chk("step_pulse", 32'(step_pulse), 32'(m_step));
            chk("dir",        32'(dir),        32'(m_dir));
            chk("moving",     32'(moving),     32'(m_mov));
            chk("period",     32'(period),     32'(m_period));
            chk("err_seq",    32'(err_seq),    32'(m_eseq));
            chk("err_cmp",    32'(err_cmp),    32'(m_ecmp));
            chk("status",     status, {m_ecmp, m_eseq, m_dir, m_mov, 7'b0, m_pos});
            if (step_pulse) n_steps++;
        end
    end

    initial begin
        int p;
        logic en;
        model_reset();
        chk_on = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        hold(6'd0, 10);

        // Forward run, 1000 cycles per phase
        n_steps = 0;
        for (int i = 0; i < 5; i++) hold(vec(1'b1, i % 4), 1000);
        chk("fwd_steps",  32'(n_steps),  32'd4);
        chk("fwd_pos",    32'(position), 32'd4);
        chk("mdl_fwd_pos", 32'(m_pos),   32'd4);
        chk("fwd_dir",    32'(dir),      32'd1);
        chk("fwd_period", 32'(period),   32'd1000);
        chk("mdl_fwd_period", 32'(m_period), 32'd1000);
        chk("fwd_errs",   32'({err_seq, err_cmp}), 32'd0);
        chk("fwd_status", status, 32'h3000_0004);

        // Backward through zero, then forward back to zero
        pos_load_val = '0;
        pos_load = 1'b1;
        tick();
        pos_load = 1'b0;
        hold(vec(1'b1, 3), 30);
        hold(vec(1'b1, 2), 30);
        chk("bwd_pos", 32'(position), 32'h1F_FFFE);
        chk("mdl_bwd_pos", 32'(m_pos), 32'h1F_FFFE);
        chk("bwd_dir", 32'(dir), 32'd0);
        hold(vec(1'b1, 3), 30);
        hold(vec(1'b1, 0), 30);
        chk("wrap_pos", 32'(position), 32'd0);

        // Glitches: 3 cycles rejected, 6 cycles step and step back
        n_steps = 0;
        hold(vec(1'b1, 1), 3);
        hold(vec(1'b1, 0), 30);
        chk("glitch3_steps", 32'(n_steps), 32'd0);
        chk("glitch3_pos", 32'(position), 32'd0);
        hold(vec(1'b1, 1), 6);
        hold(vec(1'b1, 0), 30);
        chk("glitch6_steps", 32'(n_steps), 32'd2);
        chk("glitch6_pos", 32'(position), 32'd0);
        chk("glitch_errs", 32'({err_seq, err_cmp}), 32'd0);

        // Two-state jump, complement violation, clear
        hold(vec(1'b1, 2), 30);
        chk("jump_seq", 32'(err_seq), 32'd1);
        chk("jump_pos", 32'(position), 32'd0);
        hold(vec(1'b1, 2) | 6'b000100, 10);
        hold(vec(1'b1, 2), 20);
        chk("cmp_err", 32'(err_cmp), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        hold(vec(1'b1, 2), 5);
        chk("clr_errs", 32'({err_seq, err_cmp}), 32'd0);

        // Enable low ignores pins; rising at AB=11 does not count
        for (int i = 0; i < 5; i++) hold(vec(1'b0, (2 + i) % 4), 20);
        chk("en_low_pos", 32'(position), 32'd0);
        chk("en_low_moving", 32'(moving), 32'd0);
        hold(vec(1'b1, 2), 30);
        chk("en_rise_pos", 32'(position), 32'd0);
        hold(vec(1'b1, 3), 30);
        chk("en_next_pos", 32'(position), 32'd1);

        // Asynchronous reset mid-run
        for (int i = 0; i < 3; i++) hold(vec(1'b1, i), 30);
        chk("pre_rst_pos", 32'(position), 32'd4);
        #2;
        rstn = 1'b0;
        ja   = 6'd0;
        model_reset();
        #1;
        chk("rst_pos",    32'(position), 32'd0);
        chk("rst_step",   32'(step_pulse), 32'd0);
        chk("rst_dir",    32'(dir), 32'd1);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_errs",   32'({err_seq, err_cmp}), 32'd0);
        chk("rst_status", status, 32'h2000_0000);
        @(negedge clk);
        repeat (2) tick();
        rstn = 1'b1;
        hold(6'd0, 10);
        for (int i = 0; i < 3; i++) hold(vec(1'b1, i), 30);
        chk("post_rst_pos", 32'(position), 32'd2);

        // Randomized traffic
        rnd_ctl = 1'b1;
        p  = 2;
        en = 1'b1;
        for (int s = 0; s < 1200; s++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r <= 7) begin
                p = (p + ((r % 2 == 1) ? 1 : 3)) % 4;
                hold(vec(en, p), $urandom_range(F + 1, 40));
            end else if (r == 8) begin
                p = (p + 2) % 4;
                hold(vec(en, p), $urandom_range(F + 1, 40));
            end else if (r == 9) begin
                en = ~en;
                hold(vec(en, p), $urandom_range(F + 1, 40));
            end else if (r == 10) begin
                hold(vec(en, p) ^ (6'd1 << $urandom_range(0, 5)), $urandom_range(1, F - 1));
                hold(vec(en, p), $urandom_range(F + 1, 30));
            end else if (r == 11) begin
                hold(vec(en, p) ^ 6'b000100, $urandom_range(1, 20));
                hold(vec(en, p), $urandom_range(F + 1, 30));
            end else if (r == 12) begin
                hold(6'($urandom), $urandom_range(1, 10));
                hold(vec(en, p), $urandom_range(F + 1, 30));
            end else if (r == 13) begin
                p = (p + 1) % 4;
                hold(vec(en, p), $urandom_range(1, F + 1));
            end else begin
                hold(vec(en, p), $urandom_range(1, 20));
            end
        end
        rnd_ctl = 1'b0;
        hold(ja, 20);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
